vme_cycle_sched: RTL and testbench
==================================

VME_CYCLE_SCHED -- requirements
Module: vme_cycle_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles for each wait state; legal range 2..255.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester cycle request; held until granted.
REQ-005 req_write  in  2  per-requester cycle type: 1 = write, 0 = read; sampled at grant.
REQ-006 req_ready  out  2  one-cycle grant/accept pulse to the selected requester.
REQ-007 done  out  2  one-cycle completion pulse to the owning requester.
REQ-008 err  out  2  one-cycle error pulse, coincident with done (TIMEOUT_EN only; tied 0 otherwise).
REQ-009 dsr_PLUS_, dsr_MINUS_, dsw_PLUS_, dsw_MINUS_  out  1 each  single-cycle event pulses to the VME controller FSM pair.
REQ-010 e_dtack_PLUS, e_dtack_PLUSa, e_dtack_MINUS  in  1 each  single-cycle event pulses from the controller: read ack, write ack, release.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT, START, ACK, END, and REL; all outputs SHALL be decoded from registered state only (Moore), with no combinational input-to-output path.
REQ-013 IDLE: if any req_valid is high, the block SHALL select the winner by round-robin, latch its id and req_write, and move to GRANT; otherwise it stays in IDLE.
REQ-014 Round-robin: the requester not granted last wins a tie; after reset, requester 0 wins a tie; a lone requester always wins.
REQ-015 GRANT: req_ready[id] SHALL pulse for one cycle, then the FSM moves to START.
REQ-016 START: dsw_PLUS_ SHALL pulse when the latched type is write and dsr_PLUS_ when it is read, for one cycle; the FSM then moves to ACK.
REQ-017 ACK: the FSM SHALL wait for e_dtack_PLUSa (write) or e_dtack_PLUS (read), then move to END; the wrong-type ack and e_dtack_MINUS SHALL be ignored.
REQ-018 END: dsw_MINUS_ or dsr_MINUS_ (matching the latched type) SHALL pulse for one cycle; the FSM then moves to REL.
REQ-019 REL: on e_dtack_MINUS, done[id] SHALL pulse in the following cycle, the round-robin pointer SHALL update, and the FSM returns to IDLE.
REQ-020 Minimum latency: request to req_ready is 1 cycle; req_ready to start pulse is 1 cycle; a zero-wait cycle occupies 6 cycles from IDLE back to IDLE.
REQ-021 At most one of the four event outputs SHALL be high in any cycle; no new grant SHALL occur while busy.
REQ-022 req_valid dropping after grant SHALL NOT abort the cycle in progress.

Reset
REQ-023 Reset SHALL force IDLE, clear the latched id/type, set the round-robin pointer to favour requester 0, and clear the watchdog counter.
REQ-024 During and in the cycle after reset, all outputs SHALL be 0.
REQ-025 Reset asserted mid-cycle SHALL abandon the cycle with no done, err, or MINUS pulse emitted.

Configuration
REQ-026 With VME_SCHED_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles spent in ACK and REL, clearing on each state entry.
REQ-027 Timeout in ACK (count reaches TIMEOUT_CYCLES-1 with no ack): the FSM SHALL go to END so the bus returns to idle, and set a sticky error flag.
REQ-028 Timeout in REL: the FSM SHALL pulse done[id] and err[id] and return to IDLE.
REQ-029 An ack arriving in the same cycle as a timeout SHALL win, with no error.
REQ-030 A completed cycle with the sticky error flag set SHALL pulse err[id] together with done[id].
REQ-031 Without VME_SCHED_TIMEOUT_EN, the block SHALL have no counter, SHALL wait indefinitely, and SHALL tie err to 0.

Structure
REQ-032 Package vme_sched_pkg SHALL hold the state enum, the requester id type, and the default TIMEOUT_CYCLES constant.
REQ-033 Sub-module vme_rr_arb2 (2-way round-robin arbiter: req[1:0], last pointer, grant one-hot) SHALL be instantiated once.

Verification
REQ-034 Single read, req 0: valid[0]=1, write=0; ack after 3 cycles -> ready[0]@+1, dsr_PLUS_@+2, dsr_MINUS_ one cycle after ack, done[0] one cycle after e_dtack_MINUS.
REQ-035 Simultaneous requests after reset, both write -> req 0 served first, then req 1; dsw pulses only; exactly 2 done pulses.
REQ-036 Both requesters held valid for 4 cycles -> grants alternate 0,1,0,1.
REQ-037 Wrong-type ack: read cycle receives e_dtack_PLUSa -> ignored and FSM stays in ACK; then e_dtack_PLUS -> proceeds normally.
REQ-038 TIMEOUT_EN with TIMEOUT_CYCLES=8, no ack -> dsr_MINUS_ 8 cycles after START exit, then REL; after e_dtack_MINUS, done[0] and err[0] pulse together.
REQ-039 Reset asserted in ACK -> next cycle IDLE, all outputs 0, no done; a fresh request then completes normally.

Source files
------------

// File: rtl/vme_sched_pkg.sv
// Shared types and constants for the VME cycle scheduler.
// VME_SCHED_TIMEOUT_EN enables the ACK/REL watchdog in vme_cycle_sched.
package vme_sched_pkg;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   typedef logic req_id_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_START = 3'd2,
      S_ACK   = 3'd3,
      S_END   = 3'd4,
      S_REL   = 3'd5
   } sched_state_e;

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_GRANT = S_GRANT;
   localparam logic [2:0] ST_START = S_START;
   localparam logic [2:0] ST_ACK   = S_ACK;
   localparam logic [2:0] ST_END   = S_END;
   localparam logic [2:0] ST_REL   = S_REL;

endpackage

// File: rtl/vme_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module vme_rr_arb2
   import vme_sched_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   output logic [1:0] grant
);

   always_comb begin
      grant    = 2'b00;
      grant[0] = req[0] & (~req[1] | last);
      grant[1] = req[1] & (~req[0] | ~last);
   end

endmodule

// File: rtl/vme_cycle_sched.sv
// Schedules one VME data cycle at a time for two requesters (Moore FSM).
// Define VME_SCHED_TIMEOUT_EN to add the ACK/REL watchdog and err reporting.
//
// Handshake: req_valid[i] is held until req_ready[i] pulses for one cycle;
// req_write[i] is sampled when the grant decision is taken; done[i] (and
// err[i]) pulse for one cycle after the bus is released.
module vme_cycle_sched
   import vme_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req_valid,
   input  logic [1:0]   req_write,
   output logic [1:0]   req_ready,
   output logic [1:0]   done,
   output logic [1:0]   err,
   output logic         dsr_PLUS_,
   output logic         dsr_MINUS_,
   output logic         dsw_PLUS_,
   output logic         dsw_MINUS_,
   input  logic         e_dtack_PLUS,
   input  logic         e_dtack_PLUSa,
   input  logic         e_dtack_MINUS,
   output logic         busy,
   output sched_state_e state_dbg
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("TIMEOUT_CYCLES out of range 2..255");
   end

   logic [2:0] state, state_nxt;
   req_id_t    id;
   logic       wr;
   req_id_t    last;
   logic       done_r;
   logic [1:0] grant;
   logic [1:0] sel;
   logic       run;
   logic       ack_hit;
   logic       ack_to;
   logic       rel_to;

   vme_rr_arb2 u_arb (
      .req   (req_valid),
      .last  (last),
      .grant (grant)
   );

   assign ack_hit = wr ? e_dtack_PLUSa : e_dtack_PLUS;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|req_valid) state_nxt = ST_GRANT;
         ST_GRANT: state_nxt = ST_START;
         ST_START: state_nxt = ST_ACK;
         ST_ACK:   if (ack_hit || ack_to) state_nxt = ST_END;
         ST_END:   state_nxt = ST_REL;
         ST_REL:   if (e_dtack_MINUS || rel_to) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Pointer starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         id     <= 1'b0;
         wr     <= 1'b0;
         last   <= 1'b1;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= 1'b0;
         if (state == ST_IDLE && |req_valid) begin
            id <= (grant == 2'b10);
            wr <= |(req_write & grant);
         end
         if (state == ST_REL && state_nxt == ST_IDLE) begin
            done_r <= 1'b1;
            last   <= id;
         end
      end
   end

`ifdef VME_SCHED_TIMEOUT_EN
   localparam logic [7:0] CNT_LIM = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt;
   logic       sticky;
   logic       err_r;

   // An ack or release arriving on the limit cycle wins over the timeout.
   assign ack_to = (state == ST_ACK) && !ack_hit && (cnt == CNT_LIM);
   assign rel_to = (state == ST_REL) && !e_dtack_MINUS && (cnt == CNT_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= 8'd0;
         sticky <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         err_r <= 1'b0;
         if (state != state_nxt)
            cnt <= 8'd0;
         else if (state == ST_ACK || state == ST_REL)
            cnt <= cnt + 8'd1;
         if (state == ST_GRANT)
            sticky <= 1'b0;
         else if (ack_to)
            sticky <= 1'b1;
         if (state == ST_REL && state_nxt == ST_IDLE)
            err_r <= sticky | rel_to;
      end
   end

   assign err = (run && err_r) ? sel : 2'b00;
`else
   assign ack_to = 1'b0;
   assign rel_to = 1'b0;
   assign err    = 2'b00;
`endif

   // Outputs are forced low while reset is held so an abandoned cycle emits nothing.
   assign run        = !reset;
   assign sel        = id ? 2'b10 : 2'b01;
   assign busy       = run && (state != ST_IDLE);
   assign req_ready  = (run && state == ST_GRANT) ? sel : 2'b00;
   assign done       = (run && done_r) ? sel : 2'b00;
   assign dsr_PLUS_  = run && (state == ST_START) && !wr;
   assign dsw_PLUS_  = run && (state == ST_START) && wr;
   assign dsr_MINUS_ = run && (state == ST_END) && !wr;
   assign dsw_MINUS_ = run && (state == ST_END) && wr;
   assign state_dbg  = sched_state_e'(state);

endmodule

// File: tb/tb_vme_cycle_sched.sv
// Self-checking bench for vme_cycle_sched: directed scenarios plus randomized
// cycles against a timeline model of the scheduler.
module tb_vme_cycle_sched;
   import vme_sched_pkg::*;

`ifdef VME_SCHED_TIMEOUT_EN
   localparam int TO     = 8;
   localparam int TO_LIM = TO - 1;
`else
   localparam int TO     = 64;
   localparam int TO_LIM = 1000000;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req_valid, req_write, req_ready, done, err;
   logic         dsr_PLUS_, dsr_MINUS_, dsw_PLUS_, dsw_MINUS_;
   logic         e_dtack_PLUS, e_dtack_PLUSa, e_dtack_MINUS;
   logic         busy;
   sched_state_e state_dbg;

   vme_cycle_sched #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_ready     (req_ready),
      .done          (done),
      .err           (err),
      .dsr_PLUS_     (dsr_PLUS_),
      .dsr_MINUS_    (dsr_MINUS_),
      .dsw_PLUS_     (dsw_PLUS_),
      .dsw_MINUS_    (dsw_MINUS_),
      .e_dtack_PLUS  (e_dtack_PLUS),
      .e_dtack_PLUSa (e_dtack_PLUSa),
      .e_dtack_MINUS (e_dtack_MINUS),
      .busy          (busy),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         done_cnt = 0;
   int         last_srv = 1;
   logic [1:0] exp_q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {5'b0, req_ready, done, err, dsr_PLUS_, dsr_MINUS_, dsw_PLUS_, dsw_MINUS_, busy};
   endfunction

   // evt order: {dsr_PLUS_, dsr_MINUS_, dsw_PLUS_, dsw_MINUS_}
   function automatic logic [15:0] ev(input logic [1:0] rdy, input logic [1:0] dn,
                                      input logic [1:0] er, input logic [3:0] evt,
                                      input logic bsy);
      return {5'b0, rdy, dn, er, evt, bsy};
   endfunction

   // One full bus cycle; the expected timeline follows from the scheduling rules.
   task automatic transact(input logic [1:0] vld, input logic [1:0] wr, input int ack_dly,
                           input int rel_dly, input bit noise);
      int         w, eff_ack, eff_rel;
      logic       t;
      bit         to_a, to_r;
      logic [1:0] wb, dn_exp;
      logic [3:0] plus_e, minus_e;
      w       = (vld == 2'b11) ? 1 - last_srv : (vld[1] ? 1 : 0);
      t       = wr[w];
      wb      = (w == 1) ? 2'b10 : 2'b01;
      plus_e  = t ? 4'b0010 : 4'b1000;
      minus_e = t ? 4'b0001 : 4'b0100;
      to_a    = ack_dly > TO_LIM;
      to_r    = rel_dly > TO_LIM;
      eff_ack = to_a ? TO_LIM : ack_dly;
      eff_rel = to_r ? TO_LIM : rel_dly;

      req_valid = vld;
      req_write = wr;
      step();
      chk("grant", outs(), ev(wb, 2'b00, 2'b00, 4'b0000, 1'b1));
      exp_q.push_back(wb);
      req_valid[w] = 1'b0;
      req_write    = 2'($urandom);
      step();
      chk("start", outs(), ev(2'b00, 2'b00, 2'b00, plus_e, 1'b1));
      step();
      for (int k = 0; k <= eff_ack; k++) begin
         chk("ack_wait", outs(), ev(2'b00, 2'b00, 2'b00, 4'b0000, 1'b1));
         chk("ack_state", 16'(state_dbg), 16'(S_ACK));
         if (k == eff_ack && !to_a) begin
            if (t) e_dtack_PLUSa = 1'b1;
            else   e_dtack_PLUS  = 1'b1;
         end else if (noise) begin
            if (t) e_dtack_PLUS  = 1'b1;
            else   e_dtack_PLUSa = 1'b1;
            e_dtack_MINUS = 1'($urandom);
         end
         step();
         e_dtack_PLUS  = 1'b0;
         e_dtack_PLUSa = 1'b0;
         e_dtack_MINUS = 1'b0;
      end
      chk("end", outs(), ev(2'b00, 2'b00, 2'b00, minus_e, 1'b1));
      step();
      for (int k = 0; k <= eff_rel; k++) begin
         chk("rel_wait", outs(), ev(2'b00, 2'b00, 2'b00, 4'b0000, 1'b1));
         if (k == eff_rel && !to_r) e_dtack_MINUS = 1'b1;
         step();
         e_dtack_MINUS = 1'b0;
      end
      if (done != 2'b00) done_cnt++;
      dn_exp = exp_q.pop_front();
      chk("done", outs(), ev(2'b00, dn_exp, (to_a || to_r) ? wb : 2'b00, 4'b0000, 1'b0));
      chk("idle_state", 16'(state_dbg), 16'(S_IDLE));
      last_srv = w;
   endtask

   initial begin
      int d0;
      logic [1:0] v;
      reset         = 1'b1;
      req_valid     = 2'b00;
      req_write     = 2'b00;
      e_dtack_PLUS  = 1'b0;
      e_dtack_PLUSa = 1'b0;
      e_dtack_MINUS = 1'b0;
      step();
      step();
      chk("in_reset", outs(), 16'h0000);
      reset = 1'b0;
      #1;
      chk("after_reset", outs(), 16'h0000);
      chk("reset_state", 16'(state_dbg), 16'(S_IDLE));

      // Single read from requester 0, ack after 3 wait cycles.
      transact(2'b01, 2'b00, 3, 0, 1'b0);

      // Reset in ACK abandons the cycle silently.
      req_valid = 2'b10;
      req_write = 2'b10;
      step();
      req_valid = 2'b00;
      step();
      step();
      chk("rst_in_ack_state", 16'(state_dbg), 16'(S_ACK));
      reset = 1'b1;
      #1;
      chk("rst_in_ack_outs", outs(), 16'h0000);
      step();
      reset = 1'b0;
      #1;
      chk("rst_exit_outs", outs(), 16'h0000);
      chk("rst_exit_state", 16'(state_dbg), 16'(S_IDLE));
      step();
      chk("rst_no_done", outs(), 16'h0000);
      last_srv = 1;

      // Simultaneous writes after reset: 0 first, then 1.
      d0 = done_cnt;
      transact(2'b11, 2'b11, 1, 1, 1'b0);
      transact(2'b10, 2'b11, 0, 0, 1'b0);
      chk("two_dones", 16'(done_cnt - d0), 16'd2);

      // Both held valid: grants alternate.
      for (int i = 0; i < 4; i++)
         transact(2'b11, 2'($urandom), 1, 1, 1'b0);

      // Read cycle sees wrong-type ack first.
      transact(2'b01, 2'b00, 2, 0, 1'b1);

`ifdef VME_SCHED_TIMEOUT_EN
      transact(2'b01, 2'b00, 20, 0, 1'b0);
      transact(2'b10, 2'b11, 0, 20, 1'b0);
      transact(2'b01, 2'b01, TO - 1, 0, 1'b0);
      transact(2'b10, 2'b00, 1, TO - 1, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         v = 2'($urandom_range(1, 3));
         transact(v, 2'($urandom), $urandom_range(0, (TO < 16) ? 10 : 6),
                  $urandom_range(0, (TO < 16) ? 10 : 4), 1'($urandom));
      end

      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
